// File: rtl/gf2m_pkg.sv
// Shared constants and FSM encoding for the GF(2^163) digit-serial multiplier driver.
package gf2m_pkg;
  localparam int unsigned DATA_WIDTH     = 163;
  localparam int unsigned DIGITAL        = 8;
  localparam int unsigned ITN            = (DATA_WIDTH + DIGITAL - 1) / DIGITAL;
  localparam int unsigned DATA_WIDTH_BIN = ITN * DIGITAL;
  localparam int unsigned TIMEOUT        = 4;

  // x^7 + x^6 + x^3 + 1; the x^163 term is implicit in the core.
  localparam logic [DATA_WIDTH-1:0] G163 = 163'hC9;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_FEED,
    ST_WAIT,
    ST_HOLD
  } state_e;
endpackage

// File: rtl/gf2m_digit_shifter.sv
// Padded multiplier shift register: presents b MSB-digit-first and flags the last digit.
module gf2m_digit_shifter
  import gf2m_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = gf2m_pkg::DATA_WIDTH,
  parameter int unsigned DIGITAL        = gf2m_pkg::DIGITAL,
  parameter int unsigned ITN            = gf2m_pkg::ITN,
  parameter int unsigned DATA_WIDTH_BIN = gf2m_pkg::DATA_WIDTH_BIN
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  input  logic                  shift_i,
  output logic [DIGITAL-1:0]    digit_o,
  output logic                  last_o
);
  localparam int unsigned CW = $clog2(ITN + 1);

  logic [DATA_WIDTH_BIN-1:0] b_shift_q, b_shift_d;
  logic [CW-1:0]             cnt_q, cnt_d;

  always_comb begin
    b_shift_d = b_shift_q;
    cnt_d     = cnt_q;
    if (load_i) begin
      b_shift_d = {{(DATA_WIDTH_BIN - DATA_WIDTH){1'b0}}, b_i};
      cnt_d     = '0;
    end else if (shift_i) begin
      b_shift_d = b_shift_q << DIGITAL;
      cnt_d     = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      b_shift_q <= '0;
      cnt_q     <= '0;
    end else begin
      b_shift_q <= b_shift_d;
      cnt_q     <= cnt_d;
    end
  end

  assign digit_o = b_shift_q[DATA_WIDTH_BIN-1 -: DIGITAL];
  assign last_o  = (cnt_q == CW'(ITN - 1));
endmodule

// File: rtl/gf2m_digit_driver.sv
// Initiator-side sequencer for the gf2m digit-serial core: operand handshake,
// start pulse, digit streaming, done capture with timeout, result handshake.
module gf2m_digit_driver
  import gf2m_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = gf2m_pkg::DATA_WIDTH,
  parameter int unsigned DIGITAL        = gf2m_pkg::DIGITAL,
  parameter int unsigned ITN            = gf2m_pkg::ITN,
  parameter int unsigned DATA_WIDTH_BIN = gf2m_pkg::DATA_WIDTH_BIN,
  parameter int unsigned TIMEOUT        = gf2m_pkg::TIMEOUT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_a,
  input  logic [DATA_WIDTH-1:0] in_g,
  input  logic [DATA_WIDTH-1:0] in_b,
  output logic                  core_start,
  output logic [DATA_WIDTH-1:0] core_a,
  output logic [DATA_WIDTH-1:0] core_g,
  output logic [DIGITAL-1:0]    core_b,
  input  logic [DATA_WIDTH-1:0] core_t_i_j,
  input  logic                  core_done,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_t,
  output logic                  out_err,
  output logic                  busy
);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] a_q, a_d;
  logic [DATA_WIDTH-1:0] g_q, g_d;
  logic [DATA_WIDTH-1:0] t_q, t_d;
  logic                  err_q, err_d;
  logic [TW-1:0]         to_q, to_d;
  logic                  sh_load, sh_shift, sh_last;
  logic [DIGITAL-1:0]    sh_digit;

  gf2m_digit_shifter #(
    .DATA_WIDTH    (DATA_WIDTH),
    .DIGITAL       (DIGITAL),
    .ITN           (ITN),
    .DATA_WIDTH_BIN(DATA_WIDTH_BIN)
  ) u_shifter (
    .clk    (clk),
    .rst    (rst),
    .load_i (sh_load),
    .b_i    (in_b),
    .shift_i(sh_shift),
    .digit_o(sh_digit),
    .last_o (sh_last)
  );

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    g_d      = g_q;
    t_d      = t_q;
    err_d    = err_q;
    to_d     = to_q;
    sh_load  = 1'b0;
    sh_shift = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d     = in_a;
          g_d     = in_g;
          sh_load = 1'b1;
          state_d = ST_START;
        end
      end
      ST_START: state_d = ST_FEED;
      ST_FEED: begin
        sh_shift = 1'b1;
        if (sh_last) begin
          to_d    = '0;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (core_done) begin
          t_d     = core_t_i_j;
          err_d   = 1'b0;
          state_d = ST_HOLD;
        end else if (to_q == TW'(TIMEOUT - 1)) begin
          // TIMEOUT cycles spent in WAIT without done: report error with a zero product.
          t_d     = '0;
          err_d   = 1'b1;
          state_d = ST_HOLD;
        end else begin
          to_d = to_q + 1'b1;
        end
      end
      ST_HOLD: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      g_q     <= '0;
      t_q     <= '0;
      err_q   <= 1'b0;
      to_q    <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      g_q     <= g_d;
      t_q     <= t_d;
      err_q   <= err_d;
      to_q    <= to_d;
    end
  end

  assign in_ready   = (state_q == ST_IDLE);
  assign busy       = (state_q != ST_IDLE);
  assign core_start = (state_q == ST_START);
  assign core_b     = (state_q == ST_FEED) ? sh_digit : '0;
  assign core_a     = a_q;
  assign core_g     = g_q;
  assign out_valid  = (state_q == ST_HOLD);
  assign out_t      = t_q;
  assign out_err    = err_q;
endmodule

// File: tb/tb_gf2m_digit_driver.sv
// Scoreboard bench for gf2m_digit_driver with a behavioural digit-serial core model.
module tb_gf2m_digit_driver;
  import gf2m_pkg::*;

  localparam int W = DATA_WIDTH;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready;
  logic [W-1:0] in_a, in_g, in_b;
  logic         core_start;
  logic [W-1:0] core_a, core_g, core_t_i_j;
  logic [7:0]   core_b;
  logic         core_done;
  logic         out_valid, out_ready, out_err, busy;
  logic [W-1:0] out_t;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  gf2m_digit_driver #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_g(in_g), .in_b(in_b),
    .core_start(core_start), .core_a(core_a), .core_g(core_g), .core_b(core_b),
    .core_t_i_j(core_t_i_j), .core_done(core_done),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_t(out_t), .out_err(out_err), .busy(busy)
  );

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Behavioural core: acc = acc*x^8 + a*digit mod (x^163 + g), done in the first WAIT cycle.
  function automatic logic [W-1:0] step(input logic [W-1:0] acc_in, input logic [W-1:0] a,
                                        input logic [W-1:0] g, input logic [7:0] d);
    logic [W-1:0] r;
    logic         msb;
    r = acc_in;
    for (int j = 7; j >= 0; j--) begin
      msb = r[W-1];
      r   = r << 1;
      if (msb) r = r ^ g;
      if (d[j]) r = r ^ a;
    end
    return r;
  endfunction

  logic [W-1:0] acc;
  logic         active, done_r, stub;
  int           k_core;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0; active <= 1'b0; done_r <= 1'b0; k_core <= 0;
    end else begin
      done_r <= 1'b0;
      if (core_start) begin
        acc <= '0; active <= 1'b1; k_core <= 0;
      end else if (active) begin
        acc    <= step(acc, core_a, core_g, core_b);
        k_core <= k_core + 1;
        if (k_core == int'(ITN) - 1) begin
          active <= 1'b0;
          done_r <= 1'b1;
        end
      end
    end
  end

  assign core_done  = done_r && !stub;
  assign core_t_i_j = acc;

  // Start-pulse and digit monitor.
  int           start_cnt = 0;
  int           dig_idx   = 21;
  logic [7:0]   start_b;
  logic [167:0] digs;

  always @(negedge clk) begin
    if (core_start) begin
      start_cnt++;
      start_b = core_b;
      dig_idx = 0;
    end else if (dig_idx < 21) begin
      digs = {digs[159:0], core_b};
      dig_idx++;
    end
  end

  // Scoreboard monitor: pops on every output handshake.
  logic [W-1:0] sb_t[$];
  logic         sb_e[$];
  logic [W-1:0] mon_t;
  logic         mon_e;

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb_t.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got out_t=%0h with empty scoreboard", out_t);
      end else begin
        mon_t = sb_t.pop_front();
        mon_e = sb_e.pop_front();
        chk("out_t", out_t, mon_t);
        chk("out_err", out_err, mon_e);
      end
    end
  end

  task automatic run_op(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] et, input logic ee, input int lat,
                        input int hold, input logic [167:0] ed);
    int k;
    int s0;
    @(posedge clk); #1;
    in_a = a; in_b = b; in_g = G163; in_valid = 1'b1;
    out_ready = (hold == 0);
    sb_t.push_back(et);
    sb_e.push_back(ee);
    s0 = start_cnt;
    @(negedge clk);
    chk({nm, " in_ready_pre"}, in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_a = '0; in_b = '0; in_g = '0;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!out_valid && k < 60);
    chk({nm, " latency"}, k, lat);
    if (hold > 0) begin
      for (int i = 0; i < hold; i++) begin
        chk({nm, " hold_valid"}, out_valid, 1);
        chk({nm, " hold_t"}, out_t, et);
        chk({nm, " hold_in_ready"}, in_ready, 0);
        @(negedge clk);
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      @(negedge clk);
    end
    @(negedge clk);
    chk({nm, " in_ready_after"}, in_ready, 1);
    chk({nm, " valid_after"}, out_valid, 0);
    chk({nm, " start_pulses"}, start_cnt - s0, 1);
    chk({nm, " start_digit"}, start_b, 0);
    chk({nm, " digits"}, digs, ed);
  endtask

  initial begin
    logic [W-1:0] top;
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_g = '0;
    out_ready = 1'b1; stub = 1'b0;
    #1;
    chk("rst in_ready", in_ready, 1);
    chk("rst busy", busy, 0);
    chk("rst core_start", core_start, 0);
    chk("rst core_b", core_b, 0);
    chk("rst out_valid", out_valid, 0);
    chk("rst out_t", out_t, 0);
    chk("rst out_err", out_err, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    top = 163'h1 << 162;
    run_op("identity", 163'h1, 163'h1, 163'h1, 1'b0, 24, 0, 168'h01);
    run_op("reduction", top, 163'h2, 163'hC9, 1'b0, 24, 0, 168'h02);
    run_op("digit_order", 163'h1, 163'hAB << 152, 163'hAB << 152, 1'b0, 24, 0, 168'hAB << 152);
    run_op("backpressure", 163'h3, 163'h5, 163'hF, 1'b0, 24, 5, 168'h05);
    stub = 1'b1;
    run_op("timeout", 163'h3, 163'h5, 163'h0, 1'b1, 1 + 21 + 4 + 1, 0, 168'h05);
    stub = 1'b0;

    // Abandon an operation at FEED digit 10.
    @(posedge clk); #1;
    in_a = 163'h5; in_b = 163'h7; in_g = G163; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (12) @(negedge clk);
    chk("midfeed busy", busy, 1);
    rst = 1'b1;
    #1;
    chk("midrst in_ready", in_ready, 1);
    chk("midrst busy", busy, 0);
    chk("midrst core_b", core_b, 0);
    chk("midrst core_a", core_a, 0);
    chk("midrst core_g", core_g, 0);
    chk("midrst out_valid", out_valid, 0);
    chk("midrst out_t", out_t, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    run_op("post_reset", 163'h2, 163'h2, 163'h4, 1'b0, 24, 0, 168'h02);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", sb_t.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
